// File: rtl/hdmi_pkg.sv
// Shared constants for the HDMI raster generator: 720p default timing, coordinate width,
// controller state encoding and the colour-bar palette.
package hdmi_pkg;

   localparam int unsigned CoordW = 12;

   localparam int unsigned DefHActive    = 1280;
   localparam int unsigned DefHFp        = 110;
   localparam int unsigned DefHSync      = 40;
   localparam int unsigned DefHBp        = 220;
   localparam int unsigned DefVActive    = 720;
   localparam int unsigned DefVFp        = 5;
   localparam int unsigned DefVSync      = 5;
   localparam int unsigned DefVBp        = 20;
   localparam int unsigned DefLockSettle = 1024;

   typedef enum logic [1:0] {
      StWaitLock,
      StSettle,
      StRun
   } state_e;

   localparam logic [23:0] BarWhite   = 24'hFFFFFF;
   localparam logic [23:0] BarYellow  = 24'hFFFF00;
   localparam logic [23:0] BarCyan    = 24'h00FFFF;
   localparam logic [23:0] BarGreen   = 24'h00FF00;
   localparam logic [23:0] BarMagenta = 24'hFF00FF;
   localparam logic [23:0] BarRed     = 24'hFF0000;
   localparam logic [23:0] BarBlue    = 24'h0000FF;
   localparam logic [23:0] BarBlack   = 24'h000000;

   function automatic logic [23:0] bar_colour(input logic [2:0] idx);
      logic [23:0] c;
      unique case (idx)
         3'd0: c = BarWhite;
         3'd1: c = BarYellow;
         3'd2: c = BarCyan;
         3'd3: c = BarGreen;
         3'd4: c = BarMagenta;
         3'd5: c = BarRed;
         3'd6: c = BarBlue;
         3'd7: c = BarBlack;
         default: c = BarBlack;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous level signal.
module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= 1'b0;
         q      <= 1'b0;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end

endmodule

// File: rtl/hdmi_video_timing.sv
// HDMI raster timing generator gated by a settled PLL lock.
// Define HDMI_TEST_PATTERN_EN to add the rgb colour-bar output.
module hdmi_video_timing
   import hdmi_pkg::*;
#(
   parameter int unsigned H_ACTIVE    = DefHActive,
   parameter int unsigned H_FP        = DefHFp,
   parameter int unsigned H_SYNC      = DefHSync,
   parameter int unsigned H_BP        = DefHBp,
   parameter int unsigned V_ACTIVE    = DefVActive,
   parameter int unsigned V_FP        = DefVFp,
   parameter int unsigned V_SYNC      = DefVSync,
   parameter int unsigned V_BP        = DefVBp,
   parameter bit          HS_POL      = 1'b1,
   parameter bit          VS_POL      = 1'b1,
   parameter int unsigned LOCK_SETTLE = DefLockSettle
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pll_lock,
   output logic              hsync,
   output logic              vsync,
   output logic              de,
   output logic [CoordW-1:0] x,
   output logic [CoordW-1:0] y,
   output logic              frame_start,
   output logic              running
`ifdef HDMI_TEST_PATTERN_EN
   ,
   output logic [23:0]       rgb
`endif
);

   localparam logic [CoordW-1:0] HLast    = CoordW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [CoordW-1:0] VLast    = CoordW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [CoordW-1:0] HAct     = CoordW'(H_ACTIVE);
   localparam logic [CoordW-1:0] VAct     = CoordW'(V_ACTIVE);
   localparam logic [CoordW-1:0] HsStart  = CoordW'(H_ACTIVE + H_FP);
   localparam logic [CoordW-1:0] HsEnd    = CoordW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CoordW-1:0] VsStart  = CoordW'(V_ACTIVE + V_FP);
   localparam logic [CoordW-1:0] VsEnd    = CoordW'(V_ACTIVE + V_FP + V_SYNC);
   localparam int unsigned       SettleW  = (LOCK_SETTLE > 1) ? $clog2(LOCK_SETTLE) : 1;
   localparam logic [SettleW-1:0] SettleLast = SettleW'(LOCK_SETTLE - 1);

   logic                lock_s;
   state_e              state_q, state_d;
   logic [SettleW-1:0]  settle_q, settle_d;
   logic [CoordW-1:0]   h_q, h_d, v_q, v_d;
   logic                advance, de_c, hs_c, vs_c, fs_c;
   logic [CoordW-1:0]   x_c, y_c;

   sync_2ff u_lock_sync (
      .clk   (clk),
      .reset (reset),
      .d     (pll_lock),
      .q     (lock_s)
   );

   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      h_d      = '0;
      v_d      = '0;
      unique case (state_q)
         StWaitLock: begin
            if (lock_s) begin
               state_d  = StSettle;
               settle_d = '0;
            end
         end
         StSettle: begin
            if (!lock_s) begin
               state_d = StWaitLock;
            end else if (settle_q == SettleLast) begin
               state_d = StRun;
            end else begin
               settle_d = settle_q + 1'b1;
            end
         end
         StRun: begin
            if (!lock_s) begin
               state_d = StWaitLock;
            end else begin
               h_d = (h_q == HLast) ? '0 : h_q + 1'b1;
               v_d = v_q;
               if (h_q == HLast) begin
                  v_d = (v_q == VLast) ? '0 : v_q + 1'b1;
               end
            end
         end
         default: state_d = StWaitLock;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StWaitLock;
         settle_q <= '0;
         h_q      <= '0;
         v_q      <= '0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         h_q      <= h_d;
         v_q      <= v_d;
      end
   end

   // Decode only while counting; the lock_s term makes outputs drop with the state exit.
   always_comb begin
      advance = (state_q == StRun) && lock_s;
      de_c    = advance && (h_q < HAct) && (v_q < VAct);
      hs_c    = (advance && (h_q >= HsStart) && (h_q < HsEnd)) ? HS_POL : ~HS_POL;
      vs_c    = (advance && (v_q >= VsStart) && (v_q < VsEnd)) ? VS_POL : ~VS_POL;
      fs_c    = advance && (h_q == '0) && (v_q == '0);
      x_c     = x;
      y_c     = y;
      if (!advance) begin
         x_c = '0;
         y_c = '0;
      end else if (de_c) begin
         x_c = h_q;
         y_c = v_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hsync       <= ~HS_POL;
         vsync       <= ~VS_POL;
         de          <= 1'b0;
         frame_start <= 1'b0;
         x           <= '0;
         y           <= '0;
      end else begin
         hsync       <= hs_c;
         vsync       <= vs_c;
         de          <= de_c;
         frame_start <= fs_c;
         x           <= x_c;
         y           <= y_c;
      end
   end

   assign running = (state_q == StRun);

`ifdef HDMI_TEST_PATTERN_EN
   localparam int unsigned       BarPix = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
   localparam logic [CoordW-1:0] BarWc  = CoordW'(BarPix);

   logic [CoordW-1:0] bar_sel;
   logic [2:0]        bar_idx;

   always_comb begin
      bar_sel = h_q / BarWc;
      // Leftover columns when H_ACTIVE is not a multiple of 8 stay in the last bar.
      bar_idx = (bar_sel > CoordW'(7)) ? 3'd7 : bar_sel[2:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rgb <= '0;
      end else begin
         rgb <= de_c ? bar_colour(bar_idx) : 24'h000000;
      end
   end
`endif

endmodule

// File: tb/tb_hdmi_video_timing.sv
// Self-checking bench: two polarity variants of the timing generator against a streak-based model.
module tb_hdmi_video_timing;

   localparam int HA = 16, HFP = 2, HSW = 2, HBP = 2;
   localparam int VA = 8, VFP = 1, VSW = 1, VBP = 1;
   localparam int LS = 4;
   localparam int HT = HA + HFP + HSW + HBP;
   localparam int VT = VA + VFP + VSW + VBP;
   localparam int FRAME = HT * VT;

   logic clk, reset, pll_lock;
   logic hsync_a, vsync_a, de_a, fs_a, running_a;
   logic hsync_b, vsync_b, de_b, fs_b, running_b;
   logic [11:0] x_a, y_a, x_b, y_b;
`ifdef HDMI_TEST_PATTERN_EN
   logic [23:0] rgb_a, rgb_b;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   hdmi_video_timing #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
      .HS_POL(1'b1), .VS_POL(1'b1), .LOCK_SETTLE(LS)
   ) u_dut_a (
      .clk(clk), .reset(reset), .pll_lock(pll_lock),
      .hsync(hsync_a), .vsync(vsync_a), .de(de_a), .x(x_a), .y(y_a),
      .frame_start(fs_a), .running(running_a)
`ifdef HDMI_TEST_PATTERN_EN
      , .rgb(rgb_a)
`endif
   );

   hdmi_video_timing #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
      .HS_POL(1'b0), .VS_POL(1'b0), .LOCK_SETTLE(LS)
   ) u_dut_b (
      .clk(clk), .reset(reset), .pll_lock(pll_lock),
      .hsync(hsync_b), .vsync(vsync_b), .de(de_b), .x(x_b), .y(y_b),
      .frame_start(fs_b), .running(running_b)
`ifdef HDMI_TEST_PATTERN_EN
      , .rgb(rgb_b)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: count consecutive cycles of synchronized lock; RUN needs 1 + LS of them, and
   // the raster position follows directly from how long the streak has lasted.
   logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
   bit   m_valid = 1'b0;
   bit   l1, l2;
   int   streak;
   bit   e_run, e_de, e_hs, e_vs, e_fs;
   int   e_x, e_y;
   logic [23:0] e_rgb;

   always @(posedge clk) begin : model
      int p, h, v, b;
      if (reset) begin
         m_valid = 1'b1;
         l1 = 0; l2 = 0; streak = 0;
         e_run = 0; e_de = 0; e_hs = 0; e_vs = 0; e_fs = 0; e_x = 0; e_y = 0; e_rgb = '0;
      end else begin
         streak = l2 ? streak + 1 : 0;
         l2 = l1;
         l1 = pll_lock;
         e_run = (streak >= LS + 1);
         if (streak >= LS + 2) begin
            p = (streak - LS - 2) % FRAME;
            h = p % HT;
            v = p / HT;
            e_de = (h < HA) && (v < VA);
            e_hs = (h >= HA + HFP) && (h < HA + HFP + HSW);
            e_vs = (v >= VA + VFP) && (v < VA + VFP + VSW);
            e_fs = (p == 0);
            if (e_de) begin
               e_x = h;
               e_y = v;
            end
            b = h / (HA / 8);
            e_rgb = e_de ? bars[(b > 7) ? 7 : b] : 24'h0;
         end else begin
            e_de = 0; e_hs = 0; e_vs = 0; e_fs = 0; e_x = 0; e_y = 0; e_rgb = '0;
         end
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("running_a", 32'(running_a), 32'(e_run));
         chk("de_a", 32'(de_a), 32'(e_de));
         chk("hsync_a", 32'(hsync_a), 32'(e_hs));
         chk("vsync_a", 32'(vsync_a), 32'(e_vs));
         chk("frame_start_a", 32'(fs_a), 32'(e_fs));
         chk("x_a", 32'(x_a), 32'(e_x));
         chk("y_a", 32'(y_a), 32'(e_y));
         chk("running_b", 32'(running_b), 32'(e_run));
         chk("de_b", 32'(de_b), 32'(e_de));
         chk("hsync_b", 32'(hsync_b), 32'(!e_hs));
         chk("vsync_b", 32'(vsync_b), 32'(!e_vs));
         chk("frame_start_b", 32'(fs_b), 32'(e_fs));
         chk("x_b", 32'(x_b), 32'(e_x));
         chk("y_b", 32'(y_b), 32'(e_y));
`ifdef HDMI_TEST_PATTERN_EN
         chk("rgb_a", 32'(rgb_a), 32'(e_rgb));
         chk("rgb_b", 32'(rgb_b), 32'(e_rgb));
         if (de_a && x_a == 12'd0) chk("rgb_x0_white", 32'(rgb_a), 32'h00FFFFFF);
         if (de_a && x_a == 12'd14) chk("rgb_x14_black", 32'(rgb_a), 32'h0);
`endif
      end
   end

   function automatic logic sig(input int sel);
      case (sel)
         0: return running_a;
         1: return de_a;
         2: return hsync_a;
         3: return vsync_a;
         4: return fs_a;
         default: return 1'b0;
      endcase
   endfunction

   // Advance whole cycles until the selected output reaches lvl; n is the cycle count.
   task automatic wait_lvl(input int sel, input logic lvl, input int limit, output int n);
      n = 0;
      while (sig(sel) !== lvl && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (sig(sel) !== lvl) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_sel%0d: level %0b not reached in %0d cycles", sel, lvl, limit);
      end
   endtask

   initial begin
      int n, t, t_de, t_fs, cnt, hold, r;
      reset = 1'b1;
      pll_lock = 1'b1;
      repeat (3) @(negedge clk);

      // Bring-up with lock already present, then two full frames.
      reset = 1'b0;
      t = 0;
      wait_lvl(0, 1'b1, 50, n); t += n;
      chk("run_rise_cycle", 32'(t), 32'd7);
      wait_lvl(1, 1'b1, 50, n); t += n;
      chk("first_de_cycle", 32'(t), 32'd8);
      chk("first_de_fs", 32'(fs_a), 32'd1);
      chk("first_de_x", 32'(x_a), 32'd0);
      chk("first_de_y", 32'(y_a), 32'd0);
      t_de = t; t_fs = t;
      wait_lvl(1, 1'b0, 50, n); t += n;
      chk("de_len", 32'(t - t_de), 32'd16);
      wait_lvl(2, 1'b1, 50, n); t += n;
      chk("hsync_offset", 32'(t - t_de), 32'd18);
      chk("hsync_b_low", 32'(hsync_b), 32'd0);
      wait_lvl(2, 1'b0, 50, n); t += n;
      chk("hsync_width", 32'(n), 32'd2);
      for (int f = 0; f < 2; f++) begin
         wait_lvl(4, 1'b1, 400, n); t += n;
         chk("frame_period", 32'(t - t_fs), 32'd242);
         t_fs = t;
         @(negedge clk); t++;
      end
      wait_lvl(3, 1'b1, 400, n); t += n;
      chk("vsync_b_low", 32'(vsync_b), 32'd0);
      wait_lvl(3, 1'b0, 400, n); t += n;
      chk("vsync_width", 32'(n), 32'd22);

      // Brief lock pulse shorter than the settle time.
      pll_lock = 1'b0;
      wait_lvl(0, 1'b0, 10, n);
      repeat (5) @(negedge clk);
      pll_lock = 1'b1;
      repeat (3) @(negedge clk);
      pll_lock = 1'b0;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (running_a) cnt++;
      end
      chk("short_lock_no_run", 32'(cnt), 32'd0);

      // Loss of lock at line 3 pixel 5, then re-lock.
      pll_lock = 1'b1;
      wait_lvl(4, 1'b1, 100, n);
      n = 0;
      while (!(de_a && x_a == 12'd5 && y_a == 12'd3) && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("reached_l3p5", 32'(de_a && x_a == 12'd5 && y_a == 12'd3), 32'd1);
      pll_lock = 1'b0;
      wait_lvl(0, 1'b0, 10, n);
      chk("lock_loss_latency", 32'(n), 32'd3);
      chk("lock_loss_de", 32'(de_a), 32'd0);
      pll_lock = 1'b1;
      wait_lvl(1, 1'b1, 50, n);
      chk("relock_de_cycle", 32'(n), 32'd8);
      chk("relock_fs", 32'(fs_a), 32'd1);
      chk("relock_xy", 32'({x_a, y_a}), 32'd0);

      // Reset in the middle of an active line.
      repeat (3) @(negedge clk);
      chk("pre_reset_de", 32'(de_a), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rst_de", 32'(de_a), 32'd0);
      chk("rst_sync", 32'({hsync_a, vsync_a, hsync_b, vsync_b}), 32'b0011);
      chk("rst_xy", 32'({x_a, y_a}), 32'd0);
      chk("rst_running", 32'(running_a), 32'd0);

      // Randomized lock drops and occasional resets, checked by the model every cycle.
      hold = 0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         r = int'($urandom_range(0, 999));
         reset = (r < 2);
         if (pll_lock && r >= 2 && r < 5) begin
            pll_lock = 1'b0;
            hold = int'($urandom_range(1, 8));
         end else if (!pll_lock) begin
            if (hold == 0) pll_lock = 1'b1;
            else hold--;
         end
      end
      reset = 1'b0;
      repeat (4) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
